// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor: RV32 opcodes,
// immediate extraction and PHT index hashing.
package bp_pkg;

    localparam logic [6:0] RR     = 7'b0110011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] Branch = 7'b1100011;
    localparam logic [6:0] Load   = 7'b0000011;
    localparam logic [6:0] Store  = 7'b0100011;
    localparam logic [6:0] Imm    = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JALR   = 7'b1100111;

    // Source of the next fetch PC, in priority order.
    typedef enum logic [2:0] {
        TGT_SEQ,
        TGT_MISPRED,
        TGT_JALR,
        TGT_BRANCH,
        TGT_JAL
    } tgt_sel_e;

    // Sign-extended B-type immediate.
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // Sign-extended J-type immediate.
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // PHT index from a word-aligned PC and zero-extended history.
    // mode 0 concatenates {hist, pc bits}; mode 1 XORs them.
    // The result is masked to idx_bits; callers truncate to their index width.
    function automatic logic [31:0] pht_index(
        input logic [31:0] pc,
        input logic [31:0] hist,
        input int unsigned mode,
        input int unsigned idx_bits,
        input int unsigned ghr_bits
    );
        logic [31:0] pc_w;
        logic [31:0] idx_mask;
        logic [31:0] lo_mask;
        pc_w     = pc >> 2;
        idx_mask = (32'd1 << idx_bits) - 32'd1;
        lo_mask  = (32'd1 << (idx_bits - ghr_bits)) - 32'd1;
        if (mode == 0) begin
            pht_index = ((hist << (idx_bits - ghr_bits)) | (pc_w & lo_mask)) & idx_mask;
        end else begin
            pht_index = (pc_w ^ hist) & idx_mask;
        end
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: array of saturating counters with async clear,
// one combinational read port and one increment/decrement write port.
module bp_pht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 3,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int unsigned DEPTH = 2 ** IDX_BITS;

    logic [CTR_BITS-1:0] pht_q [DEPTH];
    logic [CTR_BITS-1:0] pht_d [DEPTH];
    logic [CTR_BITS-1:0] cur_ctr;

    // Read returns the registered value, so a same-cycle write is not bypassed.
    always_comb begin
        rd_ctr = pht_q[rd_idx];
    end

    // Saturating update of the addressed counter.
    always_comb begin
        pht_d   = pht_q;
        cur_ctr = pht_q[wr_idx];
        if (wr_en) begin
            if (wr_taken) begin
                if (cur_ctr != '1) begin
                    pht_d[wr_idx] = cur_ctr + 1'b1;
                end
            end else begin
                if (cur_ctr != '0) begin
                    pht_d[wr_idx] = cur_ctr - 1'b1;
                end
            end
        end
    end

    // Counter storage; reset clears every entry to strongly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pht_q[i] <= '0;
            end
        end else begin
            pht_q <= pht_d;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: fetch-time prediction from a PC/history indexed
// PHT, EX-time resolution with redirect, and saturating statistics.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 3,
    parameter int unsigned GHR_BITS = 1,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned MODE     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         PC,
    input  logic [31:0]         Instr,
    output logic [GHR_BITS-1:0] Pred_Hist,
    input  logic                EX_valid,
    input  logic [6:0]          EX_type,
    input  logic [31:0]         EX_PC,
    input  logic [GHR_BITS-1:0] EX_Hist,
    input  logic                EX_Predict,
    input  logic                EX_Outcome,
    input  logic [31:0]         EX_Imm,
    input  logic [31:0]         EX_Result,
    output logic [31:0]         Target,
    output logic                Predict,
    output logic                Flush,
    output logic [31:0]         Branch_Cnt,
    output logic [31:0]         Mispred_Cnt
);

    if (CTR_BITS < 1 || CTR_BITS > 4) begin : g_bad_ctr_bits
        $error("gshare_predictor: CTR_BITS must be 1..4");
    end
    if (MODE > 1) begin : g_bad_mode
        $error("gshare_predictor: MODE must be 0 or 1");
    end
    if (GHR_BITS < 1 || GHR_BITS > IDX_BITS || (MODE == 0 && GHR_BITS >= IDX_BITS)) begin : g_bad_ghr_bits
        $error("gshare_predictor: GHR_BITS out of range for IDX_BITS/MODE");
    end

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         branch_cnt_q, branch_cnt_d;
    logic [31:0]         mispred_cnt_q, mispred_cnt_d;

    logic                resolve, mispred, jalr;
    logic [6:0]          fetch_op;
    logic [IDX_BITS-1:0] fetch_idx, ex_idx;
    logic [CTR_BITS-1:0] fetch_ctr;
    tgt_sel_e            tgt_sel;
    logic                unused_result_lsb;

    // Decode the EX stage and compute both PHT indices.
    always_comb begin
        resolve           = EX_valid && (EX_type == Branch);
        mispred           = resolve && (EX_Predict != EX_Outcome);
        jalr              = EX_valid && (EX_type == JALR);
        fetch_op          = Instr[6:0];
        fetch_idx         = IDX_BITS'(pht_index(PC, 32'(ghr_q), MODE, IDX_BITS, GHR_BITS));
        ex_idx            = IDX_BITS'(pht_index(EX_PC, 32'(EX_Hist), MODE, IDX_BITS, GHR_BITS));
        unused_result_lsb = EX_Result[0];
    end

    bp_pht #(
        .IDX_BITS(IDX_BITS),
        .CTR_BITS(CTR_BITS)
    ) u_pht (
        .clk     (clk),
        .rst_n   (reset),
        .rd_idx  (fetch_idx),
        .rd_ctr  (fetch_ctr),
        .wr_en   (resolve),
        .wr_idx  (ex_idx),
        .wr_taken(EX_Outcome)
    );

    // Select the next-PC source and drive the fetch outputs; reset forces sequential fetch.
    always_comb begin
        tgt_sel = TGT_SEQ;
        if (mispred) begin
            tgt_sel = TGT_MISPRED;
        end else if (jalr) begin
            tgt_sel = TGT_JALR;
        end else if (fetch_op == Branch && fetch_ctr[CTR_BITS-1]) begin
            tgt_sel = TGT_BRANCH;
        end else if (fetch_op == JAL) begin
            tgt_sel = TGT_JAL;
        end

        Flush     = 1'b0;
        Predict   = 1'b0;
        Target    = PC + 32'd4;
        Pred_Hist = '0;
        if (reset) begin
            Flush     = mispred || jalr;
            Predict   = (tgt_sel == TGT_BRANCH);
            Pred_Hist = ghr_q;
            case (tgt_sel)
                TGT_MISPRED: Target = EX_Outcome ? (EX_PC + EX_Imm) : (EX_PC + 32'd4);
                TGT_JALR:    Target = {EX_Result[31:1], 1'b0};
                TGT_BRANCH:  Target = PC + imm_b(Instr);
                TGT_JAL:     Target = PC + imm_j(Instr);
                default:     Target = PC + 32'd4;
            endcase
        end
    end

    // History shift and saturating statistics on each resolved branch.
    always_comb begin
        ghr_d         = ghr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve) begin
            // Truncating the concatenation keeps the newest GHR_BITS bits, including GHR_BITS=1.
            ghr_d = GHR_BITS'({ghr_q, EX_Outcome});
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + 32'd1;
            end
            if (mispred && mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
        end
    end

    // Predictor state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ghr_q         <= ghr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign Branch_Cnt  = branch_cnt_q;
    assign Mispred_Cnt = mispred_cnt_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: vector table on the default
// configuration plus hand sequences for reset, saturation and gshare mode.
module tb_gshare_predictor;
    import bp_pkg::*;

    localparam logic [31:0] NOP_I = 32'h0000_0013;
    localparam logic [31:0] BEQ16 = 32'h0000_0863;   // beq x0,x0,+16
    localparam logic [31:0] JAL8K = 32'h0010_006F;   // jal x0,+0x800

    logic        clk = 1'b0;
    logic        reset, g_reset;
    logic [31:0] PC, Instr, EX_PC, EX_Imm, EX_Result;
    logic        EX_valid, EX_Predict, EX_Outcome;
    logic [6:0]  EX_type;
    logic [0:0]  EX_Hist, Pred_Hist;
    logic [31:0] Target, Branch_Cnt, Mispred_Cnt;
    logic        Predict, Flush;

    logic [2:0]  g_ex_hist, g_pred_hist;
    logic [31:0] g_target, g_bcnt, g_mcnt;
    logic        g_predict, g_flush;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gshare_predictor dut (
        .clk(clk), .reset(reset), .PC(PC), .Instr(Instr), .Pred_Hist(Pred_Hist),
        .EX_valid(EX_valid), .EX_type(EX_type), .EX_PC(EX_PC), .EX_Hist(EX_Hist),
        .EX_Predict(EX_Predict), .EX_Outcome(EX_Outcome), .EX_Imm(EX_Imm),
        .EX_Result(EX_Result), .Target(Target), .Predict(Predict), .Flush(Flush),
        .Branch_Cnt(Branch_Cnt), .Mispred_Cnt(Mispred_Cnt)
    );

    gshare_predictor #(.IDX_BITS(3), .GHR_BITS(3), .CTR_BITS(2), .MODE(1)) dut_g (
        .clk(clk), .reset(g_reset), .PC(PC), .Instr(Instr), .Pred_Hist(g_pred_hist),
        .EX_valid(EX_valid), .EX_type(EX_type), .EX_PC(EX_PC), .EX_Hist(g_ex_hist),
        .EX_Predict(EX_Predict), .EX_Outcome(EX_Outcome), .EX_Imm(EX_Imm),
        .EX_Result(EX_Result), .Target(g_target), .Predict(g_predict), .Flush(g_flush),
        .Branch_Cnt(g_bcnt), .Mispred_Cnt(g_mcnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ex_valid;
        logic [6:0]  ex_type;
        logic [31:0] ex_pc;
        logic        ex_hist;
        logic        ex_pred;
        logic        ex_out;
        logic [31:0] ex_imm;
        logic [31:0] ex_res;
        logic        exp_flush;
        logic        exp_predict;
        logic [31:0] exp_target;
        logic        exp_hist;
        logic [31:0] exp_bcnt;
        logic [31:0] exp_mcnt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        EX_valid = 1'b0; EX_type = RR; EX_PC = '0; EX_Hist = '0; g_ex_hist = '0;
        EX_Predict = 1'b0; EX_Outcome = 1'b0; EX_Imm = '0; EX_Result = '0;
    endtask

    task automatic ex_branch(input logic [31:0] pc, input logic hist, input logic [2:0] ghist,
                             input logic pred, input logic outc, input logic [31:0] imm);
        EX_valid = 1'b1; EX_type = Branch; EX_PC = pc; EX_Hist = hist; g_ex_hist = ghist;
        EX_Predict = pred; EX_Outcome = outc; EX_Imm = imm; EX_Result = '0;
    endtask

    initial begin
        // pc, instr, valid, type, ex_pc, hist, pred, out, imm, res | flush, predict, target, hist, bcnt, mcnt
        vecs[0]  = '{32'h200, NOP_I, 1'b1, Branch, 32'h40, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0,   1'b0, 1'b0, 32'h204,  1'b0, 32'd0, 32'd0};
        vecs[1]  = '{32'h200, NOP_I, 1'b1, Branch, 32'h40, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0,   1'b0, 1'b0, 32'h204,  1'b1, 32'd1, 32'd0};
        vecs[2]  = '{32'h200, NOP_I, 1'b1, Branch, 32'h44, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0,   1'b0, 1'b0, 32'h204,  1'b1, 32'd2, 32'd0};
        vecs[3]  = '{32'h40,  BEQ16, 1'b0, RR,     32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b1, 32'h50,   1'b0, 32'd3, 32'd0};
        vecs[4]  = '{32'h40,  BEQ16, 1'b1, Branch, 32'h80, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0,   1'b1, 1'b0, 32'h84,   1'b0, 32'd3, 32'd0};
        vecs[5]  = '{32'h40,  BEQ16, 1'b1, Branch, 32'h80, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0,   1'b1, 1'b0, 32'hA0,   1'b0, 32'd4, 32'd1};
        vecs[6]  = '{32'h200, NOP_I, 1'b1, JALR,   32'h80, 1'b0, 1'b0, 1'b1, 32'h0,  32'h203, 1'b1, 1'b0, 32'h202,  1'b1, 32'd5, 32'd2};
        vecs[7]  = '{32'h1000, JAL8K, 1'b0, RR,    32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 32'h1800, 1'b1, 32'd5, 32'd2};
        vecs[8]  = '{32'h200, NOP_I, 1'b0, Branch, 32'h80, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0,   1'b0, 1'b0, 32'h204,  1'b1, 32'd5, 32'd2};
        vecs[9]  = '{32'h200, NOP_I, 1'b1, Load,   32'h80, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0,   1'b0, 1'b0, 32'h204,  1'b1, 32'd5, 32'd2};
        vecs[10] = '{32'h40,  BEQ16, 1'b0, RR,     32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0,   1'b0, 1'b0, 32'h44,   1'b1, 32'd5, 32'd2};

        // Reset: outputs forced even with a mispredicting branch in EX.
        reset = 1'b0; g_reset = 1'b0;
        PC = 32'h100; Instr = BEQ16;
        ex_branch(32'h80, 1'b0, 3'b000, 1'b1, 1'b0, 32'h20);
        #2;
        chk("rst flush", 32'(Flush), 32'd0);
        chk("rst predict", 32'(Predict), 32'd0);
        chk("rst target", Target, 32'h104);
        chk("rst hist", 32'(Pred_Hist), 32'd0);
        tick();
        chk("rst bcnt", Branch_Cnt, 32'd0);
        chk("rst mcnt", Mispred_Cnt, 32'd0);
        ex_idle();
        #2;
        reset = 1'b1;
        #1;
        chk("post-rst target", Target, 32'h104);
        chk("post-rst predict", 32'(Predict), 32'd0);
        tick();

        // Table on the default configuration.
        for (int i = 0; i < 11; i++) begin
            PC = vecs[i].pc; Instr = vecs[i].instr;
            EX_valid = vecs[i].ex_valid; EX_type = vecs[i].ex_type; EX_PC = vecs[i].ex_pc;
            EX_Hist = vecs[i].ex_hist; EX_Predict = vecs[i].ex_pred; EX_Outcome = vecs[i].ex_out;
            EX_Imm = vecs[i].ex_imm; EX_Result = vecs[i].ex_res;
            #1;
            chk($sformatf("v%0d flush", i), 32'(Flush), 32'(vecs[i].exp_flush));
            chk($sformatf("v%0d predict", i), 32'(Predict), 32'(vecs[i].exp_predict));
            chk($sformatf("v%0d target", i), Target, vecs[i].exp_target);
            chk($sformatf("v%0d hist", i), 32'(Pred_Hist), 32'(vecs[i].exp_hist));
            chk($sformatf("v%0d bcnt", i), Branch_Cnt, vecs[i].exp_bcnt);
            chk($sformatf("v%0d mcnt", i), Mispred_Cnt, vecs[i].exp_mcnt);
            tick();
        end

        // Saturation on idx {1,2'b10}=6; GHR is 1 here.
        PC = 32'h200; Instr = NOP_I;
        for (int k = 0; k < 5; k++) begin
            ex_branch(32'h48, 1'b1, 3'b000, 1'b1, 1'b1, 32'h10);
            tick();
        end
        chk("sat hi ctr", 32'(dut.u_pht.pht_q[6]), 32'd3);
        ex_idle();
        PC = 32'h48; Instr = BEQ16;
        #1;
        chk("sat hi predict", 32'(Predict), 32'd1);
        chk("sat hi target", Target, 32'h58);
        PC = 32'h200; Instr = NOP_I;
        for (int k = 0; k < 5; k++) begin
            ex_branch(32'h48, 1'b1, 3'b000, 1'b0, 1'b0, 32'h10);
            tick();
        end
        chk("sat lo ctr", 32'(dut.u_pht.pht_q[6]), 32'd0);
        chk("sat bcnt", Branch_Cnt, 32'd15);
        chk("sat mcnt", Mispred_Cnt, 32'd2);

        // Counter saturation at all-ones.
        ex_idle();
        force dut.branch_cnt_q = 32'hFFFF_FFFF;
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_q;
        release dut.mispred_cnt_q;
        ex_branch(32'h40, 1'b0, 3'b000, 1'b1, 1'b0, 32'h10);
        #1;
        chk("preload bcnt", Branch_Cnt, 32'hFFFF_FFFF);
        tick();
        chk("cnt sat bcnt", Branch_Cnt, 32'hFFFF_FFFF);
        chk("cnt sat mcnt", Mispred_Cnt, 32'hFFFF_FFFF);

        // Reset mid-operation: immediate clear, no update on the following edge.
        ex_branch(32'h40, 1'b0, 3'b000, 1'b0, 1'b1, 32'h10);
        PC = 32'h40; Instr = BEQ16;
        #1;
        reset = 1'b0;
        #1;
        chk("mid-rst bcnt", Branch_Cnt, 32'd0);
        chk("mid-rst mcnt", Mispred_Cnt, 32'd0);
        chk("mid-rst flush", 32'(Flush), 32'd0);
        chk("mid-rst target", Target, 32'h44);
        chk("mid-rst pht0", 32'(dut.u_pht.pht_q[0]), 32'd0);
        tick();
        chk("mid-rst edge bcnt", Branch_Cnt, 32'd0);
        chk("mid-rst edge hist", 32'(dut.ghr_q), 32'd0);
        ex_idle();
        #2;
        reset = 1'b1;

        // Gshare mode (IDX=3, GHR=3, MODE=1) on the second instance.
        PC = 32'h200; Instr = NOP_I;
        #1;
        g_reset = 1'b1;
        tick();
        ex_branch(32'h14, 1'b0, 3'b101, 1'b1, 1'b1, 32'h10);   // idx 101^101=0 -> 1
        #1;
        chk("g A flush", 32'(g_flush), 32'd0);
        tick();
        chk("g A ctr0", 32'(dut_g.u_pht.pht_q[0]), 32'd1);
        ex_branch(32'h1C, 1'b0, 3'b000, 1'b0, 1'b0, 32'h10);   // idx 7, GHR -> 010
        tick();
        ex_branch(32'h1C, 1'b0, 3'b000, 1'b1, 1'b1, 32'h10);   // idx 7, GHR -> 101
        tick();
        // Same cycle: EX updates idx 0 while fetch of 0x14 (101^101=0) reads it.
        ex_branch(32'h14, 1'b0, 3'b101, 1'b1, 1'b1, 32'h10);
        PC = 32'h14; Instr = BEQ16;
        #1;
        chk("g D hist", 32'(g_pred_hist), 32'b101);
        chk("g D predict", 32'(g_predict), 32'd0);
        chk("g D target", g_target, 32'h18);
        tick();
        // GHR is now 011, so fetch PC 0x0C maps to idx 011^011=0.
        ex_idle();
        PC = 32'h0C; Instr = BEQ16;
        #1;
        chk("g E ctr0", 32'(dut_g.u_pht.pht_q[0]), 32'd2);
        chk("g E hist", 32'(g_pred_hist), 32'b011);
        chk("g E predict", 32'(g_predict), 32'd1);
        chk("g E target", g_target, 32'h1C);
        chk("g bcnt", g_bcnt, 32'd4);
        chk("g mcnt", g_mcnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
